start_signal_seq: RTL and testbench
===================================

// Module: start_signal_seq
// PURPOSE
//   Avalon-MM-controlled sequencer for the threshold-image start handshake.
//   Software writes GO; the block drives start_out for a programmed number of cycles.
//   It then waits for done_in from the datapath, with an optional cycle timeout.
//   Sits beside the 8-bit start PIO on the same Nios bus and replaces software-timed start pulses.
// PARAMETERS
//   PULSE_W  8   width of PULSE_LEN register / pulse counter
//   TMO_W    16  width of TIMEOUT register / wait counter
// PORTS
//   clk        in   1   system clock; single clock domain
//   reset      in   1   synchronous, active-high reset
//   address    in   2   register select
//   chipselect in   1   slave select
//   write_n    in   1   active-low write strobe
//   writedata  in   32  write data
//   readdata   out  32  read data; combinational mux, zero wait states, unused bits 0
//   start_out  out  1   start pulse to datapath
//   busy_out   out  1   high whenever FSM != IDLE
//   done_in    in   1   datapath completion, level or pulse, sampled on clk
//   irq        out  1   present only with START_SEQ_IRQ_EN
// BEHAVIOUR
//   Register map. A write is chipselect & ~write_n.
//     0 CTRL    W: bit0 GO (strobe), bit1 ABORT (strobe), bit2 IRQ_EN (stored).
//               R: {29'b0, IRQ_EN, 1'b0, busy}.
//     1 STATUS  R: bit0 busy, bit1 DONE (sticky), bit2 TMO (sticky).
//               W1C on bits 1 and 2.
//     2 PULSE_LEN [PULSE_W-1:0], reset 1. Value 0 is treated as 1.
//     3 TIMEOUT   [TMO_W-1:0], reset 0. Value 0 disables the timeout.
//   Reset: FSM=IDLE; start_out=0, busy_out=0, irq=0; DONE=TMO=IRQ_EN=0; counters=0.
//   Writes to PULSE_LEN/TIMEOUT while busy are ignored; values hold for the whole run.
//   FSM IDLE -> PULSE -> WAIT -> IDLE.
//     IDLE:  GO write at edge N -> PULSE.
//            Clears DONE and TMO; loads pulse count.
//            start_out=1 and busy_out=1 from cycle N+1.
//            GO written outside IDLE is ignored.
//     PULSE: start_out=1 for exactly max(PULSE_LEN,1) cycles, then -> WAIT.
//            done_in is ignored in PULSE.
//     WAIT:  start_out=0. Wait counter starts at 0 and increments each cycle.
//            done_in=1 -> set DONE, -> IDLE.
//            TIMEOUT!=0 and count==TIMEOUT-1 with no done_in -> set TMO, -> IDLE.
//            done_in on the timeout cycle: DONE wins, TMO stays 0.
//   ABORT in PULSE/WAIT -> IDLE next edge; start_out drops; DONE/TMO not set.
//   GO+ABORT in the same write: ABORT wins, so no run starts from IDLE.
//   Status set and W1C clear on the same edge: set wins.
//   Wait counter saturates at TMO_W all-ones; it never wraps.
//   Reset asserted mid-run: immediate return to reset state at that edge.
// CONFIGURATION
//   START_SEQ_IRQ_EN defined:
//     irq = IRQ_EN & (DONE | TMO), registered, cleared via STATUS W1C.
//   START_SEQ_IRQ_EN undefined:
//     no irq port; CTRL bit2 is write-ignored and reads 0.
// TESTING
//   PULSE_LEN=3, GO, done_in pulse 5 cyc later -> start_out high 3 cyc; DONE=1; busy_out low after done.
//   TIMEOUT=10, GO, no done_in -> TMO=1 at the 10th WAIT cycle; DONE=0; FSM IDLE.
//   PULSE_LEN=0, GO -> start_out high exactly 1 cycle.
//   ABORT during WAIT; then GO+ABORT in one write from IDLE -> IDLE, no DONE/TMO; second write starts nothing.
//   done_in on the same cycle as the timeout -> DONE=1, TMO=0. GO while busy -> ignored, no restart.
//   IRQ_EN=1 (macro on), run to DONE -> irq=1; write STATUS=0x2 -> irq=0 next cycle.

Source files
------------

// File: rtl/start_signal_seq_if.sv
// start_signal_seq_if: Avalon-MM slave register bus for the start sequencer.
// The master modport drives the bus and the slave modport answers with readdata.
interface start_signal_seq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, chipselect, write_n, writedata, input readdata);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/start_signal_seq.sv
// start_signal_seq: Avalon-MM sequencer that drives a start pulse and then waits for done with an optional timeout.
// Defining START_SEQ_IRQ_EN adds the stored IRQ_EN bit and the registered irq output.
module start_signal_seq #(
    parameter int PULSE_W = 8,
    parameter int TMO_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    start_signal_seq_if.slave bus,
    output logic              start_out,
    output logic              busy_out,
    input  logic              done_in
`ifdef START_SEQ_IRQ_EN
    ,
    output logic              irq
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} state_t;
    state_t             state_q, state_d;
    logic [PULSE_W-1:0] len_q, len_d, pcnt_q, pcnt_d;
    logic [TMO_W-1:0]   lim_q, lim_d, wcnt_q, wcnt_d;
    logic               done_q, done_d, tmo_q, tmo_d;
    logic               wr, go, abort, start, set_done, set_tmo, busy, irq_en;
    logic               unused_wdata;
    assign unused_wdata = ^bus.writedata;
    assign busy = state_q != S_IDLE;
    assign start_out = state_q == S_PULSE;
    assign busy_out = busy;
    always_comb begin
        wr = bus.chipselect & ~bus.write_n;
        go = wr & (bus.address == 2'd0) & bus.writedata[0];
        abort = wr & (bus.address == 2'd0) & bus.writedata[1];
        state_d = state_q;
        pcnt_d = pcnt_q;
        wcnt_d = wcnt_q;
        start = 1'b0;
        set_done = 1'b0;
        set_tmo = 1'b0;
        // ABORT outranks GO, done and timeout alike
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (go) begin
                    start = 1'b1;
                    state_d = S_PULSE;
                    pcnt_d = (len_q == '0) ? PULSE_W'(1) : len_q;
                end
                S_PULSE: if (pcnt_q == PULSE_W'(1)) begin
                    state_d = S_WAIT;
                    wcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q - PULSE_W'(1);
                end
                S_WAIT: if (done_in) begin
                    set_done = 1'b1;
                    state_d = S_IDLE;
                end else if (lim_q != '0 && wcnt_q == lim_q - TMO_W'(1)) begin
                    set_tmo = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + TMO_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
        len_d = (wr && bus.address == 2'd2 && !busy) ? bus.writedata[PULSE_W-1:0] : len_q;
        lim_d = (wr && bus.address == 2'd3 && !busy) ? bus.writedata[TMO_W-1:0] : lim_q;
        done_d = set_done | (done_q & ~start & ~(wr & (bus.address == 2'd1) & bus.writedata[1]));
        tmo_d = set_tmo | (tmo_q & ~start & ~(wr & (bus.address == 2'd1) & bus.writedata[2]));
    end
    always_comb begin
        bus.readdata = (bus.address == 2'd0) ? {29'b0, irq_en, 1'b0, busy} :
                       (bus.address == 2'd1) ? {29'b0, tmo_q, done_q, busy} :
                       (bus.address == 2'd2) ? 32'(len_q) : 32'(lim_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q <= PULSE_W'(1);
            lim_q <= '0;
            pcnt_q <= '0;
            wcnt_q <= '0;
            done_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            lim_q <= lim_d;
            pcnt_q <= pcnt_d;
            wcnt_q <= wcnt_d;
            done_q <= done_d;
            tmo_q <= tmo_d;
        end
    end
`ifdef START_SEQ_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en = irq_en_q;
    assign irq = irq_q;
    assign irq_en_d = (wr && bus.address == 2'd0) ? bus.writedata[2] : irq_en_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q <= irq_en_d & (done_d | tmo_d);
        end
    end
`else
    assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_start_signal_seq.sv
// tb_start_signal_seq: directed self-checking bench for start_signal_seq.
// Bus writes are driven between rising edges; outputs are sampled on falling edges.
module tb_start_signal_seq;
    logic clk = 1'b0;
    logic reset, start_out, busy_out, done_in;
`ifdef START_SEQ_IRQ_EN
    logic irq;
`endif
    int checks = 0;
    int errors = 0;
    int c, c2;
    start_signal_seq_if bif();
    start_signal_seq dut (
        .clk(clk),
        .reset(reset),
        .bus(bif),
        .start_out(start_out),
        .busy_out(busy_out),
        .done_in(done_in)
`ifdef START_SEQ_IRQ_EN
        ,
        .irq(irq)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bif.address = a;
        bif.writedata = d;
        bif.chipselect = 1'b1;
        bif.write_n = 1'b0;
        @(negedge clk);
        bif.chipselect = 1'b0;
        bif.write_n = 1'b1;
    endtask
    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bif.address = a;
        #1;
        chk(tag, bif.readdata, exp);
    endtask
    task automatic count_start(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cnt += int'(start_out);
            @(negedge clk);
        end
    endtask
    task automatic pulse_done();
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
    initial begin
        bif.address = 2'd0;
        bif.writedata = 32'd0;
        bif.chipselect = 1'b0;
        bif.write_n = 1'b1;
        done_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_start", start_out, 0);
        chk("rst_busy", busy_out, 0);
        chk_rd("rst_ctrl", 2'd0, 32'h0);
        chk_rd("rst_status", 2'd1, 32'h0);
        chk_rd("rst_len", 2'd2, 32'h1);
        chk_rd("rst_tmo", 2'd3, 32'h0);
`ifdef START_SEQ_IRQ_EN
        chk("rst_irq", irq, 0);
`endif
        // three-cycle pulse, then done
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1);
        count_start(6, c);
        chk("len3_pulse", c, 3);
        chk("len3_busy_wait", busy_out, 1);
        chk_rd("len3_status_wait", 2'd1, 32'h1);
        pulse_done();
        chk("len3_busy_done", busy_out, 0);
        chk_rd("len3_status_done", 2'd1, 32'h2);
        // timeout after ten wait cycles
        wr(2'd3, 32'd10);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h1);
        repeat (10) @(negedge clk);
        chk("tmo_busy_before", busy_out, 1);
        chk_rd("tmo_status_before", 2'd1, 32'h1);
        @(negedge clk);
        chk("tmo_busy_after", busy_out, 0);
        chk_rd("tmo_status_after", 2'd1, 32'h4);
        // zero length behaves as one, then abort in WAIT
        wr(2'd2, 32'd0);
        chk_rd("len0_read", 2'd2, 32'h0);
        wr(2'd0, 32'h1);
        count_start(4, c);
        chk("len0_pulse", c, 1);
        chk("abort_busy_before", busy_out, 1);
        wr(2'd0, 32'h2);
        chk("abort_busy", busy_out, 0);
        chk_rd("abort_status", 2'd1, 32'h0);
        repeat (12) @(negedge clk);
        chk_rd("abort_status_late", 2'd1, 32'h0);
        wr(2'd0, 32'h3);
        chk("goabort_busy", busy_out, 0);
        chk("goabort_start", start_out, 0);
        repeat (3) @(negedge clk);
        chk("goabort_busy_late", busy_out, 0);
        chk_rd("goabort_status", 2'd1, 32'h0);
        // done_in on the timeout cycle
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h1);
        repeat (10) @(negedge clk);
        chk("race_busy_before", busy_out, 1);
        pulse_done();
        chk("race_busy", busy_out, 0);
        chk_rd("race_status", 2'd1, 32'h2);
        // GO while busy and config writes while busy are ignored
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h1);
        c = int'(start_out);
        wr(2'd0, 32'h1);
        count_start(8, c2);
        chk("gobusy_pulse", c + c2, 4);
        wr(2'd2, 32'd7);
        wr(2'd3, 32'd3);
        chk_rd("busy_len_hold", 2'd2, 32'h4);
        chk_rd("busy_tmo_hold", 2'd3, 32'd10);
        chk_rd("busy_ctrl", 2'd0, 32'h1);
        pulse_done();
        chk_rd("gobusy_status", 2'd1, 32'h2);
        wr(2'd1, 32'h2);
        chk_rd("w1c_status", 2'd1, 32'h0);
        // IRQ enable bit and irq output
        wr(2'd0, 32'h4);
`ifdef START_SEQ_IRQ_EN
        chk_rd("irqen_ctrl", 2'd0, 32'h4);
`else
        chk_rd("irqen_ctrl", 2'd0, 32'h0);
`endif
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h5);
        repeat (3) @(negedge clk);
        pulse_done();
        chk_rd("irq_status", 2'd1, 32'h2);
`ifdef START_SEQ_IRQ_EN
        chk("irq_set", irq, 1);
`endif
        wr(2'd1, 32'h2);
        chk_rd("irq_status_clr", 2'd1, 32'h0);
`ifdef START_SEQ_IRQ_EN
        chk("irq_clr", irq, 0);
`endif
        // reset mid-run
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h1);
        chk("midrst_start_before", start_out, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_start", start_out, 0);
        chk("midrst_busy", busy_out, 0);
        chk_rd("midrst_len", 2'd2, 32'h1);
        chk_rd("midrst_tmo", 2'd3, 32'h0);
        chk_rd("midrst_ctrl", 2'd0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
